rtc_display_scan: RTL

- Consumes the 24-bit BCD stopwatch count (MM:SS.hh, six nibbles) and drives a time-multiplexed 6-digit common-anode seven-segment display.
- Sits between the 24-bit BCD counter output and the board display pins.
- Provides a frame-aligned snapshot so digits never tear mid-scan.
- Adds ghost-blanking, leading-zero suppression, separator decimal points and BCD-error detection.

---
 rtl/rtc_display_scan.sv | 78 +++++++
 1 files changed

// File: rtl/rtc_display_scan.sv
// rtc_display_scan: time-multiplexed 6-digit seven-segment driver for an MM:SS.hh BCD count.
module rtc_display_scan #(
  parameter logic [15:0] REFRESH_DIV = 16'd50000,
  parameter logic [15:0] BLANK_CYC   = 16'd500,
  parameter logic [5:0]  DP_MASK     = 6'b010100
) (
  input  logic        i_rtcclk,
  input  logic        i_reset_n,
  input  logic [23:0] i_count,
  input  logic        i_hold,
  input  logic        i_blank_lz,
  output logic [5:0]  o_anode,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic        o_bcderr
);
  logic [15:0] p_q, p_d;
  logic [2:0]  idx_q, idx_d;
  logic [23:0] snap_q, snap_d;
  logic [5:0]  anode_q, anode_d;
  logic [6:0]  seg_q, seg_d, dec;
  logic        dp_q, dp_d, err_q, err_d;
  logic        last_p, blank, lz_blank;
  logic [23:0] upper;
  logic [3:0]  nib;
  always_comb begin
    last_p   = p_q == REFRESH_DIV - 16'd1;
    p_d      = last_p ? 16'd0 : p_q + 16'd1;
    idx_d    = last_p ? (idx_q == 3'd5 ? 3'd0 : idx_q + 3'd1) : idx_q;
    snap_d   = (last_p && idx_q == 3'd5 && !i_hold) ? i_count : snap_q;
    // upper holds digits idx..5, so zero means everything from this digit up is zero
    upper    = snap_q >> {idx_q, 2'b00};
    nib      = upper[3:0];
    blank    = p_q < BLANK_CYC;
    lz_blank = i_blank_lz && idx_q >= 3'd3 && upper == 24'h0;
    dec      = 7'h3F;
    case (nib)
      4'd0: dec = 7'h40;
      4'd1: dec = 7'h79;
      4'd2: dec = 7'h24;
      4'd3: dec = 7'h30;
      4'd4: dec = 7'h19;
      4'd5: dec = 7'h12;
      4'd6: dec = 7'h02;
      4'd7: dec = 7'h78;
      4'd8: dec = 7'h00;
      4'd9: dec = 7'h10;
      default: dec = 7'h3F;
    endcase
    anode_d  = blank ? 6'h3F : ~(6'd1 << idx_q);
    seg_d    = lz_blank ? 7'h7F : dec;
    dp_d     = (blank || lz_blank) ? 1'b1 : ~DP_MASK[idx_q];
    err_d    = err_q | (nib > 4'd9);
  end
  always_ff @(posedge i_rtcclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      p_q     <= 16'd0;
      idx_q   <= 3'd0;
      snap_q  <= 24'h0;
      anode_q <= 6'h3F;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      p_q     <= p_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      err_q   <= err_d;
    end
  end
  assign o_anode  = anode_q;
  assign o_seg    = seg_q;
  assign o_dp     = dp_q;
  assign o_bcderr = err_q;
endmodule
